// File: rtl/top.sv
// Serial pattern detector: Moore FSM flagging PATTERN (MSB first) on input stream.
// Define TOP_DET_COUNT_EN to add a saturating 8-bit match counter port.
module top #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter bit                   OVERLAP   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out
`ifdef TOP_DET_COUNT_EN
    ,
    output logic [7:0] det_count
`endif
);

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;

    localparam logic [3:0] S_DET = 4'(PATTERN_W);

    // Longest prefix of PATTERN that is a suffix of (history of state k) + b.
    function automatic logic [3:0] next_of(input int k, input logic b);
        logic [8:0] h;
        int         hl;
        int         best;
        logic       hit;
        h  = '0;
        hl = 0;
        if (!(k == PATTERN_W && !OVERLAP)) begin
            for (int i = 0; i < k; i++) begin
                h = {h[7:0], PATTERN[PATTERN_W-1-i]};
            end
            hl = k;
        end
        h    = {h[7:0], b};
        hl   = hl + 1;
        best = 0;
        for (int j = 1; j <= PATTERN_W; j++) begin
            if (j <= hl) begin
                hit = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (h[i] != PATTERN[PATTERN_W-j+i]) begin
                        hit = 1'b0;
                    end
                end
                if (hit) begin
                    best = j;
                end
            end
        end
        return 4'(best);
    endfunction

    // Unused encodings above S_PATTERN_W map to S0.
    function automatic logic [63:0] build_tbl(input logic b);
        logic [63:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            if (k <= PATTERN_W) begin
                t[k*4 +: 4] = next_of(k, b);
            end
        end
        return t;
    endfunction

    localparam logic [63:0] NXT0 = build_tbl(1'b0);
    localparam logic [63:0] NXT1 = build_tbl(1'b1);

    state_t     r_state;
    logic       r_out;
    logic [5:0] w_idx;
    logic [3:0] w_nxt;
    logic       w_hit;

    assign w_idx = {r_state, 2'b00};
    assign w_nxt = in ? NXT1[w_idx +: 4] : NXT0[w_idx +: 4];
    assign w_hit = (w_nxt == S_DET);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
            r_out   <= 1'b0;
        end else begin
            r_state <= state_t'(w_nxt);
            r_out   <= w_hit;
        end
    end

    assign out = r_out;

`ifdef TOP_DET_COUNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (w_hit && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign det_count = r_cnt;
`endif

endmodule

// File: tb/tb_top.sv
// Directed bench for the 1010 detector: overlap and non-overlap instances side by side.
module tb_top;

    logic clk;
    logic rst;
    logic din;
    logic out_ov;
    logic out_no;
`ifdef TOP_DET_COUNT_EN
    logic [7:0] cnt_ov;
    logic [7:0] cnt_no;
`endif

    int total;
    int bad;

    top #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_dut (
        .clk(clk),
        .rst(rst),
        .in (din),
        .out(out_ov)
`ifdef TOP_DET_COUNT_EN
        ,
        .det_count(cnt_ov)
`endif
    );

    top #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_dut_no (
        .clk(clk),
        .rst(rst),
        .in (din),
        .out(out_no)
`ifdef TOP_DET_COUNT_EN
        ,
        .det_count(cnt_no)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic i;
        logic eo;
        logic en;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_rst();
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic add_seq(input int n, input logic [15:0] ins,
                           input logic [15:0] eo, input logic [15:0] en);
        for (int k = n - 1; k >= 0; k--) begin
            vecs.push_back('{1'b1, ins[k], eo[k], en[k]});
        end
    endtask

    task automatic bit_in(input logic b);
        @(negedge clk);
        rst = 1'b1;
        din = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        din   = 1'b0;

        // Reset held 10 ns with in toggling.
        for (int k = 0; k < 4; k++) begin
            #2.5 din = ~din;
            chk("rst_hold_ov", {7'd0, out_ov}, 8'd0);
            chk("rst_hold_no", {7'd0, out_no}, 8'd0);
        end
`ifdef TOP_DET_COUNT_EN
        chk("rst_cnt", cnt_ov, 8'd0);
`endif

        add_rst();
        add_seq(6, 16'b101010, 16'b000101, 16'b000100);
        add_seq(2, 16'b00,     16'b00,     16'b00);
        add_rst();
        add_seq(5, 16'b11010,  16'b00001,  16'b00001);
        add_rst();
        add_seq(5, 16'b10010,  16'b00000,  16'b00000);
        add_rst();
        add_seq(9, 16'b010101010, 16'b000010101, 16'b000010001);
        add_seq(3, 16'b011,    16'b000,    16'b000);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            rst = vecs[v].r;
            din = vecs[v].i;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", v), {7'd0, out_ov}, {7'd0, vecs[v].eo});
            chk($sformatf("vec%0d_no", v), {7'd0, out_no}, {7'd0, vecs[v].en});
        end

        // Overlap count, then asynchronous drop of a high out.
        @(negedge clk);
        rst = 1'b0;
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("ovl_pulse2", {7'd0, out_ov}, 8'd1);
`ifdef TOP_DET_COUNT_EN
        chk("ovl_cnt", cnt_ov, 8'd2);
        chk("novl_cnt", cnt_no, 8'd1);
`endif
        rst = 1'b0;
        #1;
        chk("async_drop", {7'd0, out_ov}, 8'd0);
`ifdef TOP_DET_COUNT_EN
        chk("async_cnt", cnt_ov, 8'd0);
`endif

        // Partial prefix discarded by a mid-sequence reset.
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bit_in(1'b0);
        chk("mid_rst_ov", {7'd0, out_ov}, 8'd0);
        chk("mid_rst_no", {7'd0, out_no}, 8'd0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("after_rst_ov", {7'd0, out_ov}, 8'd1);
        chk("after_rst_no", {7'd0, out_no}, 8'd1);
        bit_in(1'b0);
        chk("one_cycle", {7'd0, out_ov}, 8'd0);

`ifdef TOP_DET_COUNT_EN
        // 301 repetitions of "10" yield 300 overlapped matches.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit_in(1'b1);
            bit_in(1'b0);
        end
        chk("cnt_4", cnt_ov, 8'd4);
        for (int k = 5; k < 301; k++) begin
            bit_in(1'b1);
            bit_in(1'b0);
        end
        chk("cnt_sat", cnt_ov, 8'd255);
        chk("cnt_sat_out", {7'd0, out_ov}, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Serial pattern detector: one FSM that samples a 1-bit stream `in` on every rising clock edge.
- Asserts `out` for exactly one cycle after the 4-bit pattern 1010 (first bit first) is received; overlapping occurrences are detected by default.
- Sits at the top of the FSM lab hierarchy, driven straight from stimulus/switches; no handshake, one bit per cycle.

Parameters:
- PATTERN_W, 4: pattern length in bits (2..8 supported).
- PATTERN, 4'b1010: pattern to detect; MSB is received first.
- OVERLAP, 1: 1 = a match's trailing bits may start the next match; 0 = after a match, restart from empty history.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in  input  1  serial data bit, sampled every rising clk edge.
- out  output  1  match flag, Moore output, high one cycle per detected pattern.

Behaviour:
- Reset: rst low immediately (asynchronously) forces state = S0 and out = 0. Both are held while rst is low. The first sample is taken at the first rising clk edge with rst high.
- Every rising edge with rst high samples exactly one bit of `in`; there is no enable or idle cycle.
- State encoding: state k (0..PATTERN_W) = length of the longest prefix of PATTERN that is a suffix of the bits received since reset. S_PATTERN_W is the "detected" state.
- For the default pattern 1010 the states and transitions are:
  - S0 (empty): in=1 -> S1; in=0 -> S0.
  - S1 ("1"): in=0 -> S2; in=1 -> S1.
  - S2 ("10"): in=1 -> S3; in=0 -> S0.
  - S3 ("101"): in=0 -> S4; in=1 -> S1.
  - S4 ("1010", detected), OVERLAP=1: in=1 -> S3; in=0 -> S0.
  - S4, OVERLAP=0: in=1 -> S1; in=0 -> S0.
- Generic PATTERN: the next state is computed by prefix/failure-function rules (longest prefix that is a suffix of history+in). The table may be computed at elaboration (generate/function); no runtime tables.
- Output: out = (state == S_PATTERN_W), registered.
  - Latency: out rises on the clock edge that samples the last pattern bit, so it is visible in the cycle after that bit is presented.
  - out is high for exactly one cycle per match.
- Back-to-back matches, OVERLAP=1:
  - 1010 then 10 (stream 101010) produces a second pulse 2 cycles after the first.
  - OVERLAP=0 requires 4 fresh bits after a match.
- Reset mid-sequence: a partial prefix is discarded, and out drops immediately if it was high.
- X/Z on `in`: no special handling; the bench must drive `in` to a known value whenever rst is high.
- Invalid state encodings (unused codes) go to S0 on the next edge.

Optional Feature:
- Macro: TOP_DET_COUNT_EN.
- Defined:
  - Adds output port `det_count`, 8 bits, after `out`.
  - Cleared to 0 by rst (asynchronously).
  - Increments by 1 on each edge where the state enters S_PATTERN_W.
  - Saturates at 255 and does not wrap.
  - Updates in the same cycle that out rises.
- Not defined: the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 10 ns with in toggling -> out=0 throughout; det_count=0 if enabled.
- Single match: release rst, drive 1,0,1,0 on four consecutive edges -> out=1 for exactly the cycle after the 4th bit, then 0.
- Overlap: drive 1,0,1,0,1,0 with OVERLAP=1 -> two one-cycle pulses, after bits 4 and 6. With OVERLAP=0 -> one pulse only. det_count=2 (enabled, OVERLAP=1).
- Near-miss/restart: drive 1,1,0,1,0 -> one pulse after the 5th bit. Drive 1,0,0,1,0 -> no pulse.
- Reset mid-operation: drive 1,0,1, then pulse rst low, then 0 -> no pulse. The next full 1,0,1,0 -> pulse.
- Saturation (enabled): 300 overlapped matches -> det_count holds at 255.
